// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-high glyph table and pattern decoder.
// Segment bit order is g f e d c b a, MSB to LSB.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  localparam seg_t SEG_BLANK = 7'h00;

  localparam seg_t SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Illegal patterns decode to legal=0, blank=0, nibble=0.
  function automatic seg_dec_t seg7_decode(input seg_t seg);
    seg_dec_t r;
    r = '0;
    if (seg == SEG_BLANK) r.blank = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_GLYPH[i]) begin
        r.legal  = 1'b1;
        r.nibble = i[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_readback_if.sv
// Change-event stream of the segment readback block (valid/ready).
interface seg7_readback_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_idx;
  logic [3:0] ev_val;
  logic       ev_blank;
  logic       ev_illegal;

  modport master (output ev_valid, ev_idx, ev_val, ev_blank, ev_illegal, input ev_ready);
  modport slave  (input ev_valid, ev_idx, ev_val, ev_blank, ev_illegal, output ev_ready);
endinterface

// File: rtl/seg7_digit_filter.sv
// Per-digit glitch filter: a pattern must be seen STABLE_CYCLES times in a row
// before it replaces the committed pattern.
module seg7_digit_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  seg_t sample,
  output seg_t committed,
  output logic commit
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  seg_t       last;
  logic [7:0] cnt;

  // Fires on the STABLE_CYCLES-1 -> STABLE_CYCLES step only, so a pattern that
  // re-stabilises to the already committed value stays silent.
  assign commit = (sample == last) && (cnt == CNT_MAX - 8'd1) && (sample != committed);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last      <= SEG_BLANK;
      cnt       <= '0;
      committed <= SEG_BLANK;
    end else begin
      last <= sample;
      if (sample != last)     cnt <= 8'd1;
      else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
      if (commit) committed <= sample;
    end
  end

endmodule

// File: rtl/seg7_readback.sv
// Recovers hex nibbles from active-low HEX segment buses and reports every
// committed change on a valid/ready event stream.
//
// state | meaning
// IDLE  | no event presented, waiting for a pending digit
// HOLD  | event register valid, waiting for ev_ready
module seg7_readback
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7*NUM_DIGITS-1:0] hex_in,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_ok,
  output logic                    err_sticky,
  input  logic                    err_clr,
  seg7_readback_if.master         ev
);

  localparam logic IDLE = 1'b0;
  localparam logic HOLD = 1'b1;

  // Synchroniser resets to all-ones so the first samples read as blank.
  logic [7*NUM_DIGITS-1:0] hex_sync1, hex_sync2;
  seg_t                    sample    [NUM_DIGITS];
  seg_t                    committed [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   commit;
  logic [NUM_DIGITS-1:0]   pending;
  logic [NUM_DIGITS-1:0]   sel_mask;
  logic [2:0]              sel_idx;
  seg_t                    sel_seg;
  seg_dec_t                sel_dec;
  logic                    ill_commit;
  logic                    load;
  logic                    state;

  logic [2:0] ev_idx_r;
  logic [3:0] ev_val_r;
  logic       ev_blank_r, ev_illegal_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_sync1 <= '1;
      hex_sync2 <= '1;
    end else begin
      hex_sync1 <= hex_in;
      hex_sync2 <= hex_sync1;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign sample[k] = ~hex_sync2[7*k +: 7];

    seg7_digit_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
      .clk       (clk),
      .reset_n   (reset_n),
      .sample    (sample[k]),
      .committed (committed[k]),
      .commit    (commit[k])
    );
  end

  always_comb begin
    seg_dec_t d;
    seg_dec_t n;
    digit_val  = '0;
    digit_ok   = '0;
    ill_commit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      d = seg7_decode(committed[k]);
      n = seg7_decode(sample[k]);
      digit_val[4*k +: 4] = d.legal ? d.nibble : 4'h0;
      digit_ok[k]         = d.legal;
      if (commit[k] && !n.legal && !n.blank) ill_commit = 1'b1;
    end
  end

  // Lowest pending index wins; scanning downward leaves the lowest last.
  always_comb begin
    sel_idx  = '0;
    sel_seg  = SEG_BLANK;
    sel_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (pending[k]) begin
        sel_idx     = 3'(k);
        sel_seg     = committed[k];
        sel_mask    = '0;
        sel_mask[k] = 1'b1;
      end
    end
  end

  assign sel_dec = seg7_decode(sel_seg);
  assign load    = (|pending) && ((state == IDLE) || ev.ev_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= '0;
      err_sticky   <= 1'b0;
      state        <= IDLE;
      ev_idx_r     <= '0;
      ev_val_r     <= '0;
      ev_blank_r   <= 1'b0;
      ev_illegal_r <= 1'b0;
    end else begin
      // A commit landing on the digit being loaded keeps it pending.
      pending <= (pending & ~(load ? sel_mask : '0)) | commit;

      if (ill_commit)   err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;

      case (state)
        IDLE:    if (load) state <= HOLD;
        HOLD:    if (ev.ev_ready && !load) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (load) begin
        ev_idx_r     <= sel_idx;
        ev_val_r     <= sel_dec.legal ? sel_dec.nibble : 4'h0;
        ev_blank_r   <= sel_dec.blank;
        ev_illegal_r <= !sel_dec.legal && !sel_dec.blank;
      end
    end
  end

  assign ev.ev_valid   = (state == HOLD);
  assign ev.ev_idx     = ev_idx_r;
  assign ev.ev_val     = ev_val_r;
  assign ev.ev_blank   = ev_blank_r;
  assign ev.ev_illegal = ev_illegal_r;

endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback: expected events are queued by the stimulus
// and popped by an independent monitor on each accepted handshake.
module tb_seg7_readback;

  localparam int N  = 6;
  localparam int SC = 4;

  typedef struct {
    logic [2:0] idx;
    logic [3:0] val;
    logic       blank;
    logic       illegal;
  } ev_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [7*N-1:0]   hex_in;
  logic [4*N-1:0]   digit_val;
  logic [N-1:0]     digit_ok;
  logic             err_sticky;
  logic             err_clr;

  seg7_readback_if ev_if ();

  seg7_readback #(.NUM_DIGITS(N), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hex_in     (hex_in),
    .digit_val  (digit_val),
    .digit_ok   (digit_ok),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .ev         (ev_if.master)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int idx, input int val, input logic blank, input logic illegal);
    ev_t e;
    e.idx = 3'(idx);
    e.val = 4'(val);
    e.blank = blank;
    e.illegal = illegal;
    exp_q.push_back(e);
  endtask

  task automatic set_digit(input int k, input logic [6:0] seg);
    hex_in[7*k +: 7] = ~seg;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!ev_if.ev_valid && n < max_cycles) begin
      step(1);
      n++;
    end
    chk("ev_valid_timeout", 32'(ev_if.ev_valid), 32'd1);
  endtask

  // Monitor: every accepted event must match the head of the queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset_n && ev_if.ev_valid && ev_if.ev_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ev_unexpected: idx %0d val %0h blank %0b illegal %0b",
                   ev_if.ev_idx, ev_if.ev_val, ev_if.ev_blank, ev_if.ev_illegal);
        end else begin
          e = exp_q.pop_front();
          if (ev_if.ev_idx !== e.idx || ev_if.ev_val !== e.val ||
              ev_if.ev_blank !== e.blank || ev_if.ev_illegal !== e.illegal) begin
            errors++;
            $display("FAIL ev_stream: got idx %0d val %0h blank %0b illegal %0b expected idx %0d val %0h blank %0b illegal %0b",
                     ev_if.ev_idx, ev_if.ev_val, ev_if.ev_blank, ev_if.ev_illegal,
                     e.idx, e.val, e.blank, e.illegal);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    hex_in          = '1;
    err_clr         = 1'b0;
    ev_if.ev_ready  = 1'b1;
    step(3);
    chk("rst_ev_valid",   32'(ev_if.ev_valid), 32'd0);
    chk("rst_digit_val",  32'(digit_val), 32'd0);
    chk("rst_digit_ok",   32'(digit_ok), 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    reset_n = 1'b1;

    // Blank inputs after reset: nothing commits.
    step(10);
    chk("idle_digit_ok", 32'(digit_ok), 32'd0);
    chk("idle_err",      32'(err_sticky), 32'd0);
    chk("idle_valid",    32'(ev_if.ev_valid), 32'd0);

    // Digit 0 -> '2', latency 2 + STABLE_CYCLES.
    push_ev(0, 2, 1'b0, 1'b0);
    set_digit(0, 7'h5B);
    step(5);
    chk("lat_before_ok0", 32'(digit_ok[0]), 32'd0);
    step(1);
    chk("lat_val0", 32'(digit_val[3:0]), 32'd2);
    chk("lat_ok0",  32'(digit_ok[0]), 32'd1);
    step(6);

    // Digit 3 toggles faster than the filter, then settles on '1'.
    for (int i = 0; i < 5; i++) begin
      set_digit(3, 7'h3F);
      step(2);
      set_digit(3, 7'h06);
      step(2);
    end
    chk("toggle_no_ok3", 32'(digit_ok[3]), 32'd0);
    push_ev(3, 1, 1'b0, 1'b0);
    step(12);
    chk("settle_val3", 32'(digit_val[15:12]), 32'd1);

    // Digits 1 and 4 commit together under back-pressure.
    ev_if.ev_ready = 1'b0;
    push_ev(1, 14, 1'b0, 1'b0);
    push_ev(4, 15, 1'b0, 1'b0);
    set_digit(1, 7'h79);
    set_digit(4, 7'h71);
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(ev_if.ev_valid), 32'd1);
      chk("hold_idx",   32'(ev_if.ev_idx), 32'd1);
      chk("hold_val",   32'(ev_if.ev_val), 32'hE);
      step(1);
    end
    ev_if.ev_ready = 1'b1;
    step(1);
    chk("b2b_valid", 32'(ev_if.ev_valid), 32'd1);
    chk("b2b_idx",   32'(ev_if.ev_idx), 32'd4);
    chk("b2b_val",   32'(ev_if.ev_val), 32'hF);
    step(1);
    chk("b2b_drop_valid", 32'(ev_if.ev_valid), 32'd0);

    // Illegal pattern on digit 2, then clear the sticky flag.
    push_ev(2, 0, 1'b0, 1'b1);
    set_digit(2, 7'h01);
    step(10);
    chk("ill_err",   32'(err_sticky), 32'd1);
    chk("ill_ok2",   32'(digit_ok[2]), 32'd0);
    chk("ill_val2",  32'(digit_val[11:8]), 32'd0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("err_clr", 32'(err_sticky), 32'd0);

    // Reset while an event is held; committed state returns to blank.
    ev_if.ev_ready = 1'b0;
    push_ev(5, 0, 1'b0, 1'b0);
    set_digit(5, 7'h3F);
    wait_valid(20);
    chk("held_idx5", 32'(ev_if.ev_idx), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid",     32'(ev_if.ev_valid), 32'd0);
    chk("async_digit_val", 32'(digit_val), 32'd0);
    chk("async_digit_ok",  32'(digit_ok), 32'd0);
    exp_q.delete();
    push_ev(0, 2, 1'b0, 1'b0);
    push_ev(1, 14, 1'b0, 1'b0);
    push_ev(2, 0, 1'b0, 1'b1);
    push_ev(3, 1, 1'b0, 1'b0);
    push_ev(4, 15, 1'b0, 1'b0);
    push_ev(5, 0, 1'b0, 1'b0);
    step(2);
    ev_if.ev_ready = 1'b1;
    reset_n = 1'b1;
    step(25);
    chk("regen_err",     32'(err_sticky), 32'd1);
    chk("regen_ok",      32'(digit_ok), 32'b111011);
    chk("regen_drained", 32'(exp_q.size()), 32'd0);
    chk("final_valid",   32'(ev_if.ev_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
